// File: rtl/gfx_pkg.sv
// ---------------------------------------------------------------------------
// gfx_pkg
// Shared types and constants for the pixel compositing path.
//   game_state_t : 3-bit encoding of the game flow states
//   pixel_t      : 12-bit RGB pixel, 4 bits per channel (R in [11:8])
//   fade_state_t : states of the frame-stepped fade controller
//   BRIGHT_MAX   : brightness value that leaves a pixel unchanged
//   PIPE_LAT     : clocks from compositor input to pixel_out
//   scaleChannel : scales one 4-bit channel by a 0..16 brightness
// ---------------------------------------------------------------------------
package gfx_pkg;

  typedef enum logic [2:0] {
    WELCOME = 3'd0,
    START   = 3'd1,
    PLAY    = 3'd2,
    PAUSE   = 3'd3,
    FINISH  = 3'd4
  } game_state_t;

  typedef logic [11:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    HOLD,
    FADE_IN
  } fade_state_t;

  localparam int BRIGHT_MAX = 16;
  localparam int PIPE_LAT   = 3;

  // Brightness is in sixteenths, so 16 passes the channel through unchanged.
  // The product never exceeds 15*16 = 240, so 8 bits hold it exactly.
  function automatic logic [3:0] scaleChannel(input logic [3:0] c, input logic [4:0] b);
    return 4'((8'(c) * 8'(b)) >> 4);
  endfunction

endpackage

// File: rtl/pixel_sat_add.sv
// ---------------------------------------------------------------------------
// pixel_sat_add
// Per-channel saturating sum of N RGB pixels. Each 4-bit channel is summed
// on its own (no carry into the neighbouring channel) and clamped to 4'hF.
// Ports:
//   i_pix : N packed 12-bit pixels
//   o_sum : saturated per-channel sum
// ---------------------------------------------------------------------------
module pixel_sat_add
  import gfx_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0][11:0] i_pix,
  output pixel_t             o_sum
);

  // The accumulator is wide enough that N channels of 15 can never wrap
  // before the clamp; at least 7 bits as the narrowest useful width.
  localparam int SW = (($clog2(N) + 4) > 7) ? ($clog2(N) + 4) : 7;

  logic [2:0][SW-1:0] w_acc;

  // Accumulate each channel independently across all inputs.
  always_comb begin
    w_acc = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int i = 0; i < N; i++) begin
        w_acc[ch] = w_acc[ch] + SW'(i_pix[i][ch*4 +: 4]);
      end
    end
  end

  // Clamp each channel sum to full intensity.
  always_comb begin
    o_sum = '0;
    for (int ch = 0; ch < 3; ch++) begin
      o_sum[ch*4 +: 4] = (w_acc[ch] > SW'(15)) ? 4'hF : w_acc[ch][3:0];
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// ---------------------------------------------------------------------------
// layer_compositor
// Three-stage pixel mixer: keyed sprite layers, a grid-object layer, a
// saturating sum of the floor and additive overlays, and a menu overlay are
// merged into one 12-bit pixel, then scaled by a fade brightness that steps
// once per frame whenever the game state changes.
// Ports:
//   clock, reset        : pixel clock, synchronous active-low reset
//   layer_pixel/enable  : keyed sprite layers, index 0 highest priority
//   object_pixel        : grid-object layer (keyed by SPRITE_KEY)
//   floor_pixel         : opaque background, base of the additive sum
//   add_pixel           : additive info overlays
//   menu_pixel          : menu overlay (keyed by MENU_KEY), WELCOME only
//   game_state          : requested game state
//   hcount, vcount      : pixel coordinates (not used by the mixer)
//   hsync, vsync, blank : timing inputs, delayed to *_out by 3 clocks
//   pixel_out           : composited pixel aligned with *_out
//   displayed_state     : state currently being rendered
//   fade_busy           : high while a fade is in progress
// ---------------------------------------------------------------------------
module layer_compositor
  import gfx_pkg::*;
#(
  parameter int          NUM_LAYERS = 4,
  parameter int          NUM_ADD    = 4,
  parameter logic [11:0] SPRITE_KEY = 12'hFFF,
  parameter logic [11:0] MENU_KEY   = 12'h000,
  parameter int          FADE_STEP  = 2,
  parameter bit          FADE_EN    = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_LAYERS-1:0][11:0] layer_pixel,
  input  logic [NUM_LAYERS-1:0]       layer_enable,
  input  logic [11:0]                 object_pixel,
  input  logic [11:0]                 floor_pixel,
  input  logic [NUM_ADD-1:0][11:0]    add_pixel,
  input  logic [11:0]                 menu_pixel,
  input  logic [2:0]                  game_state,
  input  logic [10:0]                 hcount,
  input  logic [9:0]                  vcount,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        blank,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        blank_out,
  output logic [11:0]                 pixel_out,
  output logic [2:0]                  displayed_state,
  output logic                        fade_busy
);

  localparam logic [4:0] BMAX5   = 5'(BRIGHT_MAX);
  localparam logic [4:0] STEP5   = 5'(FADE_STEP);
  localparam logic [4:0] IN_LAST = BMAX5 - STEP5;

  // Sync bundles are packed as {hsync, vsync, blank}.
  logic                  w_spriteHit;
  pixel_t                w_spritePix;
  logic [NUM_ADD:0][11:0] w_addIn;
  pixel_t                w_sum;
  pixel_t                w_s2Pix;
  pixel_t                w_scaled;
  logic                  w_tick;
  logic                  w_unusedCoords;

  pixel_t      r_s1Sprite, r_s1Object, r_s1Menu, r_s1Sum;
  logic        r_s1Hit;
  logic [2:0]  r_s1Sync;
  pixel_t      r_s2Pix;
  logic [2:0]  r_s2Sync;
  pixel_t      r_pixOut;
  logic [2:0]  r_syncOut;
  fade_state_t r_fadeState;
  logic [4:0]  r_bright;
  logic [2:0]  r_dispState;
  logic        r_vsyncQ;

  // Coordinates only travel alongside the pixel upstream of this block.
  assign w_unusedCoords = &{1'b0, hcount, vcount};

  // Floor is input 0 of the adder, the overlays follow it.
  assign w_addIn = {add_pixel, floor_pixel};

  pixel_sat_add #(.N(NUM_ADD + 1)) u_satAdd (
    .i_pix (w_addIn),
    .o_sum (w_sum)
  );

  // Walk from the lowest priority layer upwards so the lowest visible
  // enabled index is the last one written and therefore wins.
  always_comb begin
    w_spriteHit = 1'b0;
    w_spritePix = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_enable[i] && (layer_pixel[i] != SPRITE_KEY)) begin
        w_spriteHit = 1'b1;
        w_spritePix = layer_pixel[i];
      end
    end
  end

  // Stage 1: capture the sprite winner, the saturated sum and the keyed
  // layers that are resolved in stage 2.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1Sprite <= '0;
      r_s1Hit    <= 1'b0;
      r_s1Object <= '0;
      r_s1Menu   <= '0;
      r_s1Sum    <= '0;
      r_s1Sync   <= 3'b111;
    end else begin
      r_s1Sprite <= w_spritePix;
      r_s1Hit    <= w_spriteHit;
      r_s1Object <= object_pixel;
      r_s1Menu   <= menu_pixel;
      r_s1Sum    <= w_sum;
      r_s1Sync   <= {hsync, vsync, blank};
    end
  end

  // Priority uses the rendered state so the menu appears and disappears
  // while the screen is dark, not at the moment game_state changes.
  always_comb begin
    w_s2Pix = r_s1Sum;
    if ((r_dispState == WELCOME) && (r_s1Menu != MENU_KEY)) begin
      w_s2Pix = r_s1Menu;
    end else if (r_s1Hit) begin
      w_s2Pix = r_s1Sprite;
    end else if (r_s1Object != SPRITE_KEY) begin
      w_s2Pix = r_s1Object;
    end
  end

  // Stage 2: hold the chosen pixel.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s2Pix  <= '0;
      r_s2Sync <= 3'b111;
    end else begin
      r_s2Pix  <= w_s2Pix;
      r_s2Sync <= r_s1Sync;
    end
  end

  // Apply the fade brightness to each channel.
  always_comb begin
    w_scaled = '0;
    for (int ch = 0; ch < 3; ch++) begin
      w_scaled[ch*4 +: 4] = scaleChannel(r_s2Pix[ch*4 +: 4], r_bright);
    end
  end

  // Stage 3: output registers; blanked pixels are forced to black.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pixOut  <= '0;
      r_syncOut <= 3'b111;
    end else begin
      r_pixOut  <= r_s2Sync[0] ? 12'h000 : w_scaled;
      r_syncOut <= r_s2Sync;
    end
  end

  assign pixel_out = r_pixOut;
  assign {hsync_out, vsync_out, blank_out} = r_syncOut;

  // One pulse per frame on the falling edge of the active-low vsync.
  assign w_tick = r_vsyncQ & ~vsync;

  // Fade controller: dim to black one step per frame, swap the rendered
  // state while dark, then brighten again. A new request while brightening
  // turns around from the current level instead of jumping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fadeState <= IDLE;
      r_bright    <= BMAX5;
      r_dispState <= WELCOME;
      r_vsyncQ    <= 1'b1;
    end else begin
      r_vsyncQ <= vsync;
      if (!FADE_EN) begin
        r_fadeState <= IDLE;
        r_bright    <= BMAX5;
        r_dispState <= game_state;
      end else begin
        case (r_fadeState)
          IDLE: begin
            r_bright <= BMAX5;
            if (game_state != r_dispState) begin
              r_fadeState <= FADE_OUT;
            end
          end
          FADE_OUT: begin
            if (w_tick) begin
              if (r_bright <= STEP5) begin
                r_bright    <= '0;
                r_fadeState <= HOLD;
              end else begin
                r_bright <= r_bright - STEP5;
              end
            end
          end
          HOLD: begin
            if (w_tick) begin
              r_dispState <= game_state;
              r_fadeState <= FADE_IN;
            end
          end
          FADE_IN: begin
            if (game_state != r_dispState) begin
              r_fadeState <= FADE_OUT;
            end else if (w_tick) begin
              if (r_bright >= IN_LAST) begin
                r_bright    <= BMAX5;
                r_fadeState <= IDLE;
              end else begin
                r_bright <= r_bright + STEP5;
              end
            end
          end
          default: r_fadeState <= IDLE;
        endcase
      end
    end
  end

  assign displayed_state = r_dispState;
  assign fade_busy       = (r_fadeState != IDLE);

endmodule

// File: tb/tb_layer_compositor.sv
// ---------------------------------------------------------------------------
// tb_layer_compositor
// Directed bench for layer_compositor. Stimulus pushes expected values with
// the cycle they are due into a queue; a monitor on the falling clock edge
// compares every entry whose cycle has arrived.
// ---------------------------------------------------------------------------
module tb_layer_compositor;
  import gfx_pkg::*;

  logic             clock;
  logic             reset;
  logic [3:0][11:0] layerPixel;
  logic [3:0]       layerEnable;
  logic [11:0]      objectPixel;
  logic [11:0]      floorPixel;
  logic [3:0][11:0] addPixel;
  logic [11:0]      menuPixel;
  logic [2:0]       gameState;
  logic [10:0]      hcount;
  logic [9:0]       vcount;
  logic             hsync, vsync, blank;
  logic             hsyncOut, vsyncOut, blankOut;
  logic [11:0]      pixelOut;
  logic [2:0]       displayedState;
  logic             fadeBusy;

  typedef struct {
    int          due;
    bit          chkPix;
    logic [11:0] pix;
    bit          chkSync;
    logic [2:0]  syncs;
    bit          chkState;
    logic [2:0]  dstate;
    bit          chkBusy;
    logic        busy;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  int    cycleCount = 0;
  int    testCount  = 0;
  int    failCount  = 0;

  // Expected brightness-scaled white at each frame of the 0 -> 2 fade.
  logic [11:0] fadeAPix [17] = '{12'hDDD, 12'hBBB, 12'h999, 12'h777, 12'h555, 12'h333,
                                 12'h111, 12'h000, 12'h000, 12'h111, 12'h333, 12'h555,
                                 12'h777, 12'h999, 12'hBBB, 12'hDDD, 12'hFFF};
  logic [2:0]  fadeADisp [17] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2,
                                  3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};

  // 2 -> 4 fade, reversed to 3 while brightening at level 6.
  logic [11:0] fadeBPix [24] = '{12'hDDD, 12'hBBB, 12'h999, 12'h777, 12'h555, 12'h333,
                                 12'h111, 12'h000, 12'h000, 12'h111, 12'h333, 12'h555,
                                 12'h333, 12'h111, 12'h000, 12'h000, 12'h111, 12'h333,
                                 12'h555, 12'h777, 12'h999, 12'hBBB, 12'hDDD, 12'hFFF};
  logic [2:0]  fadeBDisp [24] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
                                  3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4,
                                  3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};

  layer_compositor dut (
    .clock           (clock),
    .reset           (reset),
    .layer_pixel     (layerPixel),
    .layer_enable    (layerEnable),
    .object_pixel    (objectPixel),
    .floor_pixel     (floorPixel),
    .add_pixel       (addPixel),
    .menu_pixel      (menuPixel),
    .game_state      (gameState),
    .hcount          (hcount),
    .vcount          (vcount),
    .hsync           (hsync),
    .vsync           (vsync),
    .blank           (blank),
    .hsync_out       (hsyncOut),
    .vsync_out       (vsyncOut),
    .blank_out       (blankOut),
    .pixel_out       (pixelOut),
    .displayed_state (displayedState),
    .fade_busy       (fadeBusy)
  );

  // 10 ns pixel clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Advance n clocks, leaving the caller just after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pushExp(input int lat, input bit cp, input logic [11:0] p,
                         input bit cs, input logic [2:0] s,
                         input bit cd, input logic [2:0] d,
                         input bit cb, input logic b, input string nm);
    exp_t e;
    e.due = cycleCount + lat;
    e.chkPix = cp;   e.pix = p;
    e.chkSync = cs;  e.syncs = s;
    e.chkState = cd; e.dstate = d;
    e.chkBusy = cb;  e.busy = b;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  // Inputs are already set by the caller; expect the pixel PIPE_LAT later.
  task automatic applyStimulus(input logic [11:0] expPix, input string nm);
    pushExp(PIPE_LAT, 1'b1, expPix, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, nm);
    step(1);
  endtask

  task automatic checkOutput(input exp_t e, input string nm);
    if (e.chkPix) begin
      testCount++;
      if (pixelOut !== e.pix) begin
        failCount++;
        $display("[TB] FAIL %s pixel_out: got %h expected %h", nm, pixelOut, e.pix);
      end
    end
    if (e.chkSync) begin
      testCount++;
      if ({hsyncOut, vsyncOut, blankOut} !== e.syncs) begin
        failCount++;
        $display("[TB] FAIL %s syncs{h,v,b}: got %b expected %b", nm,
                 {hsyncOut, vsyncOut, blankOut}, e.syncs);
      end
    end
    if (e.chkState) begin
      testCount++;
      if (displayedState !== e.dstate) begin
        failCount++;
        $display("[TB] FAIL %s displayed_state: got %0d expected %0d", nm, displayedState, e.dstate);
      end
    end
    if (e.chkBusy) begin
      testCount++;
      if (fadeBusy !== e.busy) begin
        failCount++;
        $display("[TB] FAIL %s fade_busy: got %b expected %b", nm, fadeBusy, e.busy);
      end
    end
  endtask

  // Monitor: compare entries that fall due, flag any that were skipped.
  always @(negedge clock) begin
    for (int i = expQ.size() - 1; i >= 0; i--) begin
      if (expQ[i].due == cycleCount) begin
        checkOutput(expQ[i], nameQ[i]);
        expQ.delete(i);
        nameQ.delete(i);
      end else if (expQ[i].due < cycleCount) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL %s missed: due %0d now %0d", nameQ[i], expQ[i].due, cycleCount);
        expQ.delete(i);
        nameQ.delete(i);
      end
    end
  end

  // One video frame of about 100 clocks with a vsync pulse at its start;
  // state is checked and a pixel is sampled once the frame has settled.
  task automatic frame(input logic [11:0] p, input logic [2:0] d, input logic b, input string nm);
    vsync = 1'b0;
    step(1);
    vsync = 1'b1;
    step(20);
    pushExp(0, 1'b0, 12'h000, 1'b0, 3'b000, 1'b1, d, 1'b1, b, nm);
    pushExp(PIPE_LAT, 1'b1, p, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, nm);
    step(80);
  endtask

  initial begin
    reset       = 1'b0;
    layerEnable = 4'b0001;
    layerPixel  = {12'hFFF, 12'hFFF, 12'hFFF, 12'h0F0};
    objectPixel = 12'hFFF;
    floorPixel  = 12'h000;
    addPixel    = '0;
    menuPixel   = 12'h000;
    gameState   = 3'd0;
    hcount      = 11'd0;
    vcount      = 10'd0;
    hsync       = 1'b0;
    vsync       = 1'b0;
    blank       = 1'b0;

    // Reset held for two clocks with static inputs.
    step(2);
    pushExp(0, 1'b1, 12'h000, 1'b1, 3'b111, 1'b1, 3'd0, 1'b1, 1'b0, "inReset");
    reset = 1'b1;
    pushExp(2, 1'b1, 12'h000, 1'b1, 3'b111, 1'b0, 3'd0, 1'b0, 1'b0, "lat2");
    pushExp(3, 1'b1, 12'h0F0, 1'b1, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, "lat3");
    step(4);
    hsync = 1'b1;
    vsync = 1'b1;

    // Priority and additive vectors at full brightness.
    menuPixel = 12'h123;
    applyStimulus(12'h123, "menu");
    menuPixel   = 12'h000;
    layerEnable = 4'b0110;
    layerPixel  = {12'h00F, 12'h0F0, 12'hFFF, 12'h00F};
    objectPixel = 12'hF00;
    applyStimulus(12'h0F0, "prio");
    layerEnable = 4'b0000;
    applyStimulus(12'hF00, "object");
    objectPixel = 12'hFFF;
    floorPixel  = 12'h888;
    addPixel    = {12'h000, 12'h000, 12'h000, 12'h999};
    applyStimulus(12'hFFF, "sat");
    floorPixel = 12'h123;
    addPixel   = {12'h000, 12'h000, 12'h010, 12'h111};
    applyStimulus(12'h244, "sum");
    floorPixel  = 12'h000;
    addPixel    = '0;
    layerEnable = 4'b1000;
    layerPixel  = {12'hABC, 12'h0F0, 12'h321, 12'hFFF};
    applyStimulus(12'hABC, "layer3");
    layerEnable = 4'b1111;
    applyStimulus(12'h321, "layer1");
    layerPixel  = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    objectPixel = 12'h5A5;
    applyStimulus(12'h5A5, "keyAll");

    // Blanking and 3-cycle sync alignment.
    objectPixel = 12'hFFF;
    layerEnable = 4'b0001;
    layerPixel  = {12'hFFF, 12'hFFF, 12'hFFF, 12'h0F0};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] s;
      s = 3'(i);
      {hsync, vsync, blank} = s;
      pushExp(PIPE_LAT, 1'b1, s[0] ? 12'h000 : 12'h0F0, 1'b1, s, 1'b0, 3'd0, 1'b0, 1'b0,
              $sformatf("sync%0d", i));
      step(1);
    end
    {hsync, vsync, blank} = 3'b110;

    // Fade WELCOME -> PLAY on a white floor.
    layerEnable = 4'b0000;
    floorPixel  = 12'hFFF;
    step(4);
    gameState = 3'd2;
    step(2);
    pushExp(0, 1'b0, 12'h000, 1'b0, 3'b000, 1'b1, 3'd0, 1'b1, 1'b1, "fadeStart");
    pushExp(PIPE_LAT, 1'b1, 12'hFFF, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, "fadeStartPix");
    step(4);
    for (int k = 0; k < 17; k++) begin
      frame(fadeAPix[k], fadeADisp[k], (k == 16) ? 1'b0 : 1'b1, $sformatf("fadeA%0d", k + 1));
    end

    // Fade PLAY -> FINISH, reversed to PAUSE while brightening.
    gameState = 3'd4;
    step(2);
    for (int k = 0; k < 12; k++) begin
      frame(fadeBPix[k], fadeBDisp[k], 1'b1, $sformatf("fadeB%0d", k + 1));
    end
    gameState = 3'd3;
    step(2);
    pushExp(0, 1'b0, 12'h000, 1'b0, 3'b000, 1'b1, 3'd4, 1'b1, 1'b1, "reverse");
    pushExp(PIPE_LAT, 1'b1, 12'h555, 1'b0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, "reversePix");
    step(4);
    for (int k = 12; k < 24; k++) begin
      frame(fadeBPix[k], fadeBDisp[k], (k == 23) ? 1'b0 : 1'b1, $sformatf("fadeB%0d", k + 1));
    end

    // Menu is ignored outside WELCOME.
    menuPixel   = 12'h123;
    objectPixel = 12'h0F0;
    applyStimulus(12'h0F0, "menuOff");
    menuPixel   = 12'h000;
    objectPixel = 12'hFFF;
    step(3);

    // Reset in the middle of a fade.
    gameState = 3'd1;
    step(2);
    frame(12'hDDD, 3'd3, 1'b1, "rstFade1");
    frame(12'hBBB, 3'd3, 1'b1, "rstFade2");
    reset     = 1'b0;
    gameState = 3'd0;
    step(1);
    pushExp(0, 1'b1, 12'h000, 1'b1, 3'b111, 1'b1, 3'd0, 1'b1, 1'b0, "midReset");
    reset = 1'b1;
    pushExp(PIPE_LAT, 1'b1, 12'hFFF, 1'b1, 3'b110, 1'b0, 3'd0, 1'b0, 1'b0, "rstBright");
    step(6);

    if (expQ.size() != 0) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL leftover: got %0d pending expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
